mux_sel_arbiter: RTL and testbench

//  Round-robin arbiter that drives the 2-bit select of the 4-way, 4-bit datapath mux.
//  - Four requesters compete; the winner's index goes to sel and is held until the consumer accepts.
//  - The consumer handshakes with out_valid/out_ready.
//  - Sits directly upstream of the mux: sel -> mux s, mux y -> consumer data.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/mux_sel_arbiter_if.sv | 38 +++
 rtl/rr_pick4.sv | 26 ++
 rtl/mux_sel_arbiter.sv | 112 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
package mux_arb_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_CH-1:0] ch_onehot(input ch_t ch);
        logic [N_CH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant and consumer handshake bundle of the mux-select arbiter.
// grant_cnt and the CNT_W parameter exist only when MUX_ARB_STATS_EN is defined.
interface mux_sel_arbiter_if
`ifdef MUX_ARB_STATS_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ;
    import mux_arb_pkg::*;

    logic [N_CH-1:0] req;
    logic            out_ready;
    logic            out_valid;
    ch_t             sel;
    logic [N_CH-1:0] gnt;
    logic [N_CH-1:0] ack;
`ifdef MUX_ARB_STATS_EN
    logic [N_CH*CNT_W-1:0] grant_cnt;
`endif

    // Arbiter side: drives the select, grant and handshake outputs.
    modport master (
        input  req, out_ready,
        output out_valid, sel, gnt, ack
`ifdef MUX_ARB_STATS_EN
        , output grant_cnt
`endif
    );

    // Requester/consumer side.
    modport slave (
        output req, out_ready,
        input  out_valid, sel, gnt, ack
`ifdef MUX_ARB_STATS_EN
        , input grant_cnt
`endif
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request scanning from ptr upward, mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_CH-1:0] req_i,
    input  ch_t             ptr_i,
    output logic            any_o,
    output ch_t             idx_o
);

    ch_t cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = ptr_i;
        cand  = ptr_i;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = ptr_i + ch_t'(k);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4-way datapath mux, with burst limit.
// Define MUX_ARB_STATS_EN to add saturating per-channel transfer counters (grant_cnt).
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
`ifdef MUX_ARB_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    mux_sel_arbiter_if.master  bus
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state_q;
    ch_t               sel_q;
    ch_t               ptr_q;
    logic [N_CH-1:0]   gnt_q;
    logic              out_valid_q;
    logic [BEAT_W-1:0] beat_q;

    logic [BEAT_W-1:0] beat_d;
    ch_t               pick_ptr;
    ch_t               pick_idx;
    logic              pick_any;
    logic              xfer;
    logic              burst_more;

    // A reset cycle abandons any transfer in flight, so it never acks.
    assign xfer       = (state_q == ST_GRANT) && bus.out_ready && !reset;
    assign beat_d     = beat_q + BEAT_W'(1);
    assign burst_more = bus.req[sel_q] && (beat_d < BEAT_W'(MAX_BURST));
    // While granted, the only re-pick happens at rotation, which starts just past the owner.
    assign pick_ptr   = (state_q == ST_GRANT) ? (sel_q + ch_t'(1)) : ptr_q;

    rr_pick4 u_pick (
        .req_i (bus.req),
        .ptr_i (pick_ptr),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.ack       = xfer ? gnt_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q     <= ST_GRANT;
                        sel_q       <= pick_idx;
                        gnt_q       <= ch_onehot(pick_idx);
                        out_valid_q <= 1'b1;
                        beat_q      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        if (burst_more) begin
                            beat_q <= beat_d;
                        end else begin
                            ptr_q  <= pick_ptr;
                            beat_q <= '0;
                            if (pick_any) begin
                                sel_q <= pick_idx;
                                gnt_q <= ch_onehot(pick_idx);
                            end else begin
                                state_q     <= ST_IDLE;
                                gnt_q       <= '0;
                                out_valid_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_CH];

    // Per-channel transfer counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (xfer && (cnt_q[sel_q] != '1)) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign bus.grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench: two arbiters (MAX_BURST=4 and 1) against a behavioural round-robin model.
module tb_mux_sel_arbiter;
    import mux_arb_pkg::*;

    localparam int CNT_MAX = 3;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [3:0] req_v [2];
    logic       rdy_v [2];
    logic [3:0] pend  [2];

    int m_busy [2];
    int m_ch   [2];
    int m_beat [2];
    int m_ptr  [2];
    int m_rsts [2];
    int m_cnt  [2][4];

    int exp_sel3 [5];
    int exp_sel4 [10];
    int rdy4     [10];

`ifdef MUX_ARB_STATS_EN
    mux_sel_arbiter_if #(.CNT_W(2)) bus_a ();
    mux_sel_arbiter_if #(.CNT_W(2)) bus_b ();
    mux_sel_arbiter #(.MAX_BURST(4), .CNT_W(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mux_sel_arbiter #(.MAX_BURST(1), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
`else
    mux_sel_arbiter_if bus_a ();
    mux_sel_arbiter_if bus_b ();
    mux_sel_arbiter #(.MAX_BURST(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mux_sel_arbiter #(.MAX_BURST(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mb_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus_a.req       = req_v[0];
        bus_a.out_ready = rdy_v[0];
        bus_b.req       = req_v[1];
        bus_b.out_ready = rdy_v[1];
    endtask

    task automatic drive_both(input logic [3:0] r, input logic rdy);
        for (int d = 0; d < 2; d++) begin
            req_v[d] = r;
            rdy_v[d] = rdy;
        end
        apply();
    endtask

    task automatic compare(input int d);
        logic       o_valid;
        logic [1:0] o_sel;
        logic [3:0] o_gnt;
        logic [3:0] o_ack;
        logic [3:0] e_gnt;
        logic [3:0] e_ack;
        if (d == 0) begin
            o_valid = bus_a.out_valid; o_sel = bus_a.sel; o_gnt = bus_a.gnt; o_ack = bus_a.ack;
        end else begin
            o_valid = bus_b.out_valid; o_sel = bus_b.sel; o_gnt = bus_b.gnt; o_ack = bus_b.ack;
        end
        e_gnt = (m_busy[d] != 0) ? 4'(1 << m_ch[d]) : 4'd0;
        e_ack = ((m_busy[d] != 0) && rdy_v[d] && !reset) ? e_gnt : 4'd0;
        chk($sformatf("dut%0d out_valid", d), 32'(o_valid), 32'(m_busy[d] != 0));
        chk($sformatf("dut%0d gnt", d), 32'(o_gnt), 32'(e_gnt));
        chk($sformatf("dut%0d ack", d), 32'(o_ack), 32'(e_ack));
        if (m_busy[d] != 0 || m_rsts[d] != 0)
            chk($sformatf("dut%0d sel", d), 32'(o_sel), 32'(m_busy[d] != 0 ? m_ch[d] : 0));
`ifdef MUX_ARB_STATS_EN
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("dut%0d grant_cnt[%0d]", d, c),
                32'((d == 0) ? bus_a.grant_cnt[c*2 +: 2] : bus_b.grant_cnt[c*2 +: 2]),
                32'(m_cnt[d][c]));
        end
`endif
    endtask

    task automatic model_step(input int d);
        int w;
        if (reset) begin
            m_busy[d] = 0; m_ch[d] = 0; m_beat[d] = 0; m_ptr[d] = 0; m_rsts[d] = 1;
            for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
        end else if (m_busy[d] == 0) begin
            w = pick(req_v[d], m_ptr[d]);
            if (w >= 0) begin
                m_busy[d] = 1; m_ch[d] = w; m_beat[d] = 0; m_rsts[d] = 0;
            end
        end else if (rdy_v[d]) begin
            if (m_cnt[d][m_ch[d]] < CNT_MAX) m_cnt[d][m_ch[d]]++;
            if (req_v[d][m_ch[d]] && (m_beat[d] + 1 < mb_of(d))) begin
                m_beat[d]++;
            end else begin
                m_ptr[d]  = (m_ch[d] + 1) % 4;
                m_beat[d] = 0;
                w = pick(req_v[d], m_ptr[d]);
                if (w >= 0) m_ch[d] = w;
                else        m_busy[d] = 0;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare(d);
    endtask

    task automatic advance();
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
    endtask

    task automatic gen_random(input int d);
        for (int i = 0; i < 4; i++) begin
            if (!pend[d][i] && $urandom_range(0, 7) == 0) pend[d][i] = 1'b1;
        end
        rdy_v[d] = ($urandom_range(0, 3) != 0);
        if (m_busy[d] != 0 && rdy_v[d] && $urandom_range(0, 2) == 0) pend[d][m_ch[d]] = 1'b0;
        req_v[d] = pend[d];
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_ch[d] = 0; m_beat[d] = 0; m_ptr[d] = 0; m_rsts[d] = 1;
            for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
            pend[d] = 4'd0;
        end
        exp_sel3 = '{0, 1, 2, 3, 0};
        exp_sel4 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        rdy4     = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};

        // Reset held two clocks with all requests high.
        reset = 1'b1;
        drive_both(4'b1111, 1'b1);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("reset gnt", 32'(bus_a.gnt), 32'd0);
            chk("reset out_valid", 32'(bus_a.out_valid), 32'd0);
            chk("reset sel", 32'(bus_a.sel), 32'd0);
            advance();
        end

        // Single request from idle, dropped in its ack cycle.
        reset = 1'b0;
        drive_both(4'b0100, 1'b1);
        sample();
        advance();
        drive_both(4'b0000, 1'b1);
        sample();
        chk("single sel", 32'(bus_a.sel), 32'd2);
        chk("single gnt", 32'(bus_a.gnt), 32'h4);
        chk("single ack", 32'(bus_a.ack), 32'h4);
        advance();
        sample();
        chk("single back to idle", 32'(bus_a.out_valid), 32'd0);
        advance();

        // Strict rotation on the MAX_BURST=1 instance.
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        drive_both(4'b1111, 1'b1);
        sample();
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk($sformatf("rotate sel[%0d]", i), 32'(bus_b.sel), 32'(exp_sel3[i]));
            chk($sformatf("rotate valid[%0d]", i), 32'(bus_b.out_valid), 32'd1);
            advance();
        end

        // Bursts of four with a mid-burst stall on the MAX_BURST=4 instance.
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        drive_both(4'b0011, 1'b1);
        sample();
        advance();
        for (int i = 0; i < 10; i++) begin
            drive_both(4'b0011, rdy4[i] != 0);
            sample();
            chk($sformatf("burst sel[%0d]", i), 32'(bus_a.sel), 32'(exp_sel4[i]));
            chk($sformatf("burst ack[%0d]", i), 32'(bus_a.ack),
                32'((rdy4[i] != 0) ? (1 << exp_sel4[i]) : 0));
            advance();
        end

        // Reset in the second beat of a ch3 burst.
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        drive_both(4'b1000, 1'b1);
        sample();
        advance();
        sample();
        chk("ch3 first beat ack", 32'(bus_a.ack), 32'h8);
        advance();
        reset = 1'b1;
        sample();
        chk("reset mid-burst ack", 32'(bus_a.ack), 32'd0);
        advance();
        reset = 1'b0;
        drive_both(4'b1001, 1'b1);
        sample();
        chk("after reset out_valid", 32'(bus_a.out_valid), 32'd0);
        advance();
        sample();
        chk("after reset sel", 32'(bus_a.sel), 32'd0);
        chk("after reset gnt", 32'(bus_a.gnt), 32'h1);
        advance();

`ifdef MUX_ARB_STATS_EN
        // Saturating counter: six transfers on ch1.
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0;
        drive_both(4'b0010, 1'b1);
        sample();
        advance();
        for (int i = 0; i < 6; i++) begin
            sample();
            advance();
        end
        drive_both(4'b0000, 1'b0);
        sample();
        chk("stats cnt1", 32'(bus_a.grant_cnt[2 +: 2]), 32'd3);
        chk("stats cnt0", 32'(bus_a.grant_cnt[0 +: 2]), 32'd0);
        chk("stats cnt2", 32'(bus_a.grant_cnt[4 +: 2]), 32'd0);
        chk("stats cnt3", 32'(bus_a.grant_cnt[6 +: 2]), 32'd0);
        advance();
`endif

        // Randomized traffic against the model, with occasional resets.
        reset = 1'b1;
        drive_both(4'b0000, 1'b0);
        for (int d = 0; d < 2; d++) pend[d] = 4'd0;
        sample();
        advance();
        reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            for (int d = 0; d < 2; d++) gen_random(d);
            apply();
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
